// File: rtl/flow_reshaper.sv
// flow_reshaper
//   Streaming pixel reorder engine. Reads an IMG_W x IMG_H image stored in raster order in an
//   external synchronous RAM (1-cycle read latency) and re-emits it in tile order. Tiles are
//   TILE_W x TILE_H, visited in raster order across the image. Pixels are emitted in raster
//   order inside each tile. One read is issued per cycle for the whole frame.
//
// Ports
//   clk      in   single clock, rising edge
//   rstn     in   asynchronous active-low reset
//   ena      in   start request, level-sampled, only honoured when idle
//   rd_en    out  source RAM read strobe
//   rd_addr  out  source RAM raster address y*IMG_W+x
//   rd_data  in   source RAM data, valid the cycle after rd_en/rd_addr
//   wr_en    out  output write strobe (rd_en delayed one cycle)
//   wr_addr  out  output address, sequential 0..IMG_W*IMG_H-1
//   wr_data  out  output pixel, valid one cycle after its wr_en/wr_addr
module flow_reshaper #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned TILE_W = 8,
  parameter int unsigned TILE_H = 8,
  parameter int unsigned AW     = 20,
  parameter int unsigned DW     = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ena,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  localparam int unsigned TilesX = IMG_W / TILE_W;
  localparam int unsigned TilesY = IMG_H / TILE_H;
  localparam int unsigned NumPix = IMG_W * IMG_H;

  localparam int unsigned PxW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned PyW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned TxW = (TilesX > 1) ? $clog2(TilesX) : 1;
  localparam int unsigned TyW = (TilesY > 1) ? $clog2(TilesY) : 1;

  // Address deltas applied when the named counter advances. Arithmetic is modulo 2**AW, so
  // the negative tile-column step is simply its two's complement.
  localparam logic [AW-1:0] StepPx = AW'(1);
  localparam logic [AW-1:0] StepPy = AW'(IMG_W - (TILE_W - 1));
  localparam logic [AW-1:0] StepTx = AW'(1 - (TILE_H - 1) * IMG_W);
  localparam logic [AW-1:0] StepTy = AW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;
  logic   drain_q;

  logic [PxW-1:0] px_q, px_d;
  logic [PyW-1:0] py_q, py_d;
  logic [TxW-1:0] tx_q, tx_d;
  logic [TyW-1:0] ty_q, ty_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic px_last, py_last, tx_last, ty_last, frame_last;

  assign px_last    = (px_q == PxW'(TILE_W - 1));
  assign py_last    = (py_q == PyW'(TILE_H - 1));
  assign tx_last    = (tx_q == TxW'(TilesX - 1));
  assign ty_last    = (ty_q == TyW'(TilesY - 1));
  assign frame_last = px_last & py_last & tx_last & ty_last;

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counts the two DRAIN cycles: wr_en of the last read, then its wr_data.
      drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ena)        state_d = StRun;
      StRun:   if (frame_last) state_d = StDrain;
      StDrain: if (drain_q)    state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_en = 1'b0;
    if (state_q == StRun) rd_en = 1'b1;
  end

  // Tile-order address walk, px fastest, then py, tx, ty. All counters and the address wrap
  // to zero after the last read, so the idle address is 0.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    tx_d   = tx_q;
    ty_d   = ty_q;
    addr_d = addr_q;
    if (rd_en) begin
      if (!px_last) begin
        px_d   = px_q + PxW'(1);
        addr_d = addr_q + StepPx;
      end else begin
        px_d = '0;
        if (!py_last) begin
          py_d   = py_q + PyW'(1);
          addr_d = addr_q + StepPy;
        end else begin
          py_d = '0;
          if (!tx_last) begin
            tx_d   = tx_q + TxW'(1);
            addr_d = addr_q + StepTx;
          end else begin
            tx_d = '0;
            if (!ty_last) begin
              ty_d   = ty_q + TyW'(1);
              addr_d = addr_q + StepTy;
            end else begin
              ty_d   = '0;
              addr_d = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px_q   <= '0;
      py_q   <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
      addr_q <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      addr_q <= addr_d;
    end
  end

  // Write side: wr_en is rd_en one cycle late, which is exactly when rd_data is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= rd_en;
      if (wr_en_q) begin
        wr_addr_q <= (wr_addr_q == AW'(NumPix - 1)) ? '0 : wr_addr_q + AW'(1);
        wr_data_q <= rd_data;
      end
    end
  end

  assign rd_addr = addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_flow_reshaper.sv
// Testbench for flow_reshaper. Uses IMG_W=320 with a reduced IMG_H=16 so several full frames
// fit in a short run while every tile-boundary address case (row step, tile step, tile-row
// step, last pixel) is still exercised.
module tb_flow_reshaper;

  localparam int W  = 320;
  localparam int H  = 16;
  localparam int TW = 8;
  localparam int TH = 8;
  localparam int N  = W * H;

  logic        clk;
  logic        rstn;
  logic        ena;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;

  flow_reshaper #(
    .IMG_W (W),
    .IMG_H (H),
    .TILE_W(TW),
    .TILE_H(TH),
    .AW    (20),
    .DW    (8)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .ena    (ena),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source RAM: RAM[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[7:0];
  end

  int tests;
  int fails;

  typedef struct {
    int k;
    int addr;
    int data;
  } vec_t;
  vec_t tbl[10];

  int unsigned sb[$];
  int rd_log[N];
  int data_log[N];
  int rd_idx, wr_idx, d_idx, rd_runs;
  int addr_err, wraddr_err, data_err;

  function automatic int model_addr(int k);
    int px, py, t, tx, ty;
    px = k % TW;
    py = (k / TW) % TH;
    t  = k / (TW * TH);
    tx = t % (W / TW);
    ty = t / (W / TW);
    return (ty * TH + py) * W + tx * TW + px;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: logs reads, checks write addresses, pops the scoreboard when wr_data is valid.
  initial begin
    bit prev_rd, prev_wr;
    int unsigned e;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_rd = 1'b0;
        prev_wr = 1'b0;
      end else begin
        if (rd_en === 1'b1) begin
          if (!prev_rd) rd_runs++;
          if (rd_idx < N) rd_log[rd_idx] = int'(rd_addr);
          if (int'(rd_addr) != model_addr(rd_idx)) addr_err++;
          rd_idx++;
        end
        if (wr_en === 1'b1) begin
          if (int'(wr_addr) != wr_idx) wraddr_err++;
          wr_idx++;
        end
        if (prev_wr) begin
          if (sb.size() == 0) begin
            data_err++;
          end else begin
            e = sb.pop_front();
            if ({24'd0, wr_data} !== e) data_err++;
          end
          if (d_idx < N) data_log[d_idx] = int'(wr_data);
          d_idx++;
        end
        prev_rd = (rd_en === 1'b1);
        prev_wr = (wr_en === 1'b1);
      end
    end
  end

  task automatic reset_stats();
    sb.delete();
    rd_idx     = 0;
    wr_idx     = 0;
    d_idx      = 0;
    rd_runs    = 0;
    addr_err   = 0;
    wraddr_err = 0;
    data_err   = 0;
    for (int i = 0; i < N; i++) begin
      rd_log[i]   = -1;
      data_log[i] = -1;
    end
  endtask

  // Runs one frame: ena held for ena_cycles, optional extra ena pulse mid-frame.
  task automatic run_frame(input string tag, input int ena_cycles, input bit pulse_mid);
    bit done;
    reset_stats();
    for (int k = 0; k < N; k++) sb.push_back(model_addr(k) & 32'hFF);
    ena = 1'b1;
    check({tag, " rd_en before start"}, rd_en, 0);
    @(posedge clk); #1;
    check({tag, " first rd_en"}, rd_en, 1);
    check({tag, " first rd_addr"}, rd_addr, 0);
    for (int i = 1; i < ena_cycles; i++) begin
      @(posedge clk); #1;
    end
    ena = 1'b0;
    if (pulse_mid) begin
      repeat (100) @(posedge clk);
      #1 ena = 1'b1;
      repeat (3) @(posedge clk);
      #1 ena = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < N + 100 && !done; i++) begin
      @(posedge clk); #1;
      if (rd_idx >= N && rd_en === 1'b0 && wr_en === 1'b0) done = 1'b1;
    end
    check({tag, " frame completes"}, done, 1);
    repeat (10) @(posedge clk);
    #1;
    check({tag, " read count"}, rd_idx, N);
    check({tag, " rd_en bursts"}, rd_runs, 1);
    check({tag, " write count"}, wr_idx, N);
    check({tag, " data count"}, d_idx, N);
    check({tag, " rd_addr order errors"}, addr_err, 0);
    check({tag, " wr_addr errors"}, wraddr_err, 0);
    check({tag, " wr_data errors"}, data_err, 0);
    check({tag, " scoreboard left"}, sb.size(), 0);
    check({tag, " idle rd_addr"}, rd_addr, 0);
    check({tag, " idle wr_addr"}, wr_addr, 0);
    check({tag, " idle wr_data holds"}, wr_data, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s rd_addr k=%0d", tag, tbl[i].k), rd_log[tbl[i].k], tbl[i].addr);
      check($sformatf("%s wr_data k=%0d", tag, tbl[i].k), data_log[tbl[i].k], tbl[i].data);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{k: 0,     addr: 0,     data: 8'h00};
    tbl[1] = '{k: 1,     addr: 1,     data: 8'h01};
    tbl[2] = '{k: 7,     addr: 7,     data: 8'h07};
    tbl[3] = '{k: 8,     addr: 320,   data: 8'h40};
    tbl[4] = '{k: 9,     addr: 321,   data: 8'h41};
    tbl[5] = '{k: 63,    addr: 2247,  data: 8'hC7};
    tbl[6] = '{k: 64,    addr: 8,     data: 8'h08};
    tbl[7] = '{k: 72,    addr: 328,   data: 8'h48};
    tbl[8] = '{k: 2560,  addr: 2560,  data: 8'h00};
    tbl[9] = '{k: N - 1, addr: N - 1, data: 8'hFF};
    reset_stats();

    rstn = 1'b0;
    ena  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) @(posedge clk);
    // Reset again while idle.
    #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("reset rd_en", rd_en, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset wr_en", wr_en, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    repeat (5) @(posedge clk);
    #1;
    check("idle no reads", rd_idx, 0);

    // Multi-cycle start pulse starts exactly one frame.
    run_frame("frame1", 6, 1'b0);
    // Extra ena pulse during RUN must be ignored; this is also the post-idle restart.
    run_frame("frame2", 2, 1'b1);

    // Abort mid-frame with an asynchronous reset.
    ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("abort rd_en before reset", rd_en, 1);
    #2 rstn = 1'b0;
    #1;
    check("abort rd_en async", rd_en, 0);
    check("abort wr_en async", wr_en, 0);
    check("abort rd_addr async", rd_addr, 0);
    check("abort wr_addr async", wr_addr, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check("abort idle rd_en", rd_en, 0);
    run_frame("frame3", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
